// File: rtl/counter_arbiter.sv
// Round-robin command arbiter/sequencer for the shared 32-bit counter.
// Each command runs IDLE->EXEC->CAPT->ACK with registered outputs.
module counter_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  input  logic [31:0] counter_value,
  output logic        counter_reset,
  output logic        counter_double
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_id;
  logic        r_last;
  logic [1:0]  r_op;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_busy;
  logic        r_clr;
  logic        r_dbl;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_gnt;
  logic [1:0]  w_op;

  // On a tie the requester not granted last wins
  assign w_req = req0 | req1;
  assign w_gnt = (req0 & req1) ? ~r_last : req1;
  assign w_op  = w_gnt ? op1 : op0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_op    <= 2'b00;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
      r_dbl   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_op    <= w_op;
            r_clr   <= w_op[0];
            r_dbl   <= (w_op == 2'b10);
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_clr <= 1'b0;
          r_dbl <= 1'b0;
          // SNAP and RCLR read the pre-op value
          if (r_op[0] == r_op[1])
            r_rdata <= counter_value;
          r_state <= CAPT;
        end
        CAPT: begin
          if (r_op[0] != r_op[1])
            r_rdata <= counter_value;
          r_ack0  <= ~r_id;
          r_ack1  <= r_id;
          r_state <= ACK;
        end
        ACK: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0           = r_ack0;
  assign ack1           = r_ack1;
  assign busy           = r_busy;
  assign rdata          = r_rdata;
  assign counter_double = r_dbl;
  assign counter_reset  = reset | r_clr;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed self-checking bench for counter_arbiter with a
// behavioural model of the shared counter.
module tb_counter_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic        req1;
  logic [1:0]  op0;
  logic [1:0]  op1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] counter_value;
  logic        counter_reset;
  logic        counter_double;

  logic        load;
  logic [31:0] load_val;

  int checks = 0;
  int errors = 0;

  counter_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .req1           (req1),
    .op0            (op0),
    .op1            (op1),
    .ack0           (ack0),
    .ack1           (ack1),
    .rdata          (rdata),
    .busy           (busy),
    .counter_value  (counter_value),
    .counter_reset  (counter_reset),
    .counter_double (counter_double)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter; load lets the bench preset the EXEC-cycle value
  always_ff @(posedge clk) begin
    if (counter_reset)
      counter_value <= 32'd0;
    else if (counter_double)
      counter_value <= counter_value << 1;
    else if (load)
      counter_value <= load_val;
    else
      counter_value <= counter_value + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic id,
                         input logic [1:0] op, input logic [31:0] pre,
                         input logic [31:0] exp_capt,
                         input logic [31:0] exp_rd, input logic tgl);
    @(negedge clk);
    load     = 1'b1;
    load_val = pre;
    if (id) begin req1 = 1'b1; op1 = op; end
    else    begin req0 = 1'b1; op0 = op; end
    @(negedge clk);
    load = 1'b0;
    chk({tag, " exec busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " exec crst"}, {31'd0, counter_reset}, {31'd0, op[0]});
    chk({tag, " exec cdbl"}, {31'd0, counter_double},
        {31'd0, op == 2'b10});
    if (tgl) begin
      if (id) op1 = 2'b10;
      else    op0 = 2'b10;
    end
    @(negedge clk);
    chk({tag, " capt cnt"}, counter_value, exp_capt);
    chk({tag, " capt ctrl"},
        {30'd0, counter_reset, counter_double}, 32'd0);
    @(negedge clk);
    chk({tag, " ack0"}, {31'd0, ack0}, {31'd0, ~id});
    chk({tag, " ack1"}, {31'd0, ack1}, {31'd0, id});
    chk({tag, " rdata"}, rdata, exp_rd);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk({tag, " idle"}, {29'd0, busy, ack0, ack1}, 32'd0);
    chk({tag, " hold"}, rdata, exp_rd);
  endtask

  initial begin
    reset    = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    op0      = 2'b00;
    op1      = 2'b00;
    load     = 1'b0;
    load_val = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst outs",
        {28'd0, ack0, ack1, busy, counter_double}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst crst", {31'd0, counter_reset}, 32'd1);
    chk("rst cnt", counter_value, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("run cnt", counter_value, 32'd2);
    chk("run crst", {31'd0, counter_reset}, 32'd0);

    run_cmd("snap0", 1'b0, 2'b00, 32'h10, 32'h11, 32'h10, 1'b0);
    run_cmd("dbl1", 1'b1, 2'b10, 32'h8000_0003,
            32'h6, 32'h6, 1'b0);
    chk("dbl cont", counter_value, 32'h8);
    run_cmd("rclr0", 1'b0, 2'b11, 32'h1234, 32'h0, 32'h1234, 1'b0);
    run_cmd("clr0", 1'b0, 2'b01, 32'h55, 32'h0, 32'h0, 1'b0);

    // Reset during CAPT of a CLEAR aborts without ack
    @(negedge clk);
    req0 = 1'b1;
    op0  = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("abort capt busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort crst", {31'd0, counter_reset}, 32'd1);
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort noack", {30'd0, ack0, ack1}, 32'd0);
      chk("abort crst hi", {31'd0, counter_reset}, 32'd1);
    end
    reset = 1'b0;
    run_cmd("post rst", 1'b0, 2'b00, 32'h77, 32'h78, 32'h77, 1'b0);

    // Op change during EXEC is ignored
    run_cmd("tgl1", 1'b1, 2'b01, 32'h99, 32'h0, 32'h0, 1'b1);

    // Both requesters held from reset release
    @(negedge clk);
    reset = 1'b1;
    op0   = 2'b00;
    op1   = 2'b00;
    req0  = 1'b1;
    req1  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk($sformatf("rr ack0 n%0d", n), {31'd0, ack0},
          {31'd0, (n == 3) || (n == 11)});
      chk($sformatf("rr ack1 n%0d", n), {31'd0, ack1},
          {31'd0, (n == 7) || (n == 15)});
    end
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge clk);
    chk("final busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
